beep_decode: RTL

BEEP_DECODE -- requirements
Module: beep_decode

---
 rtl/beep_decode.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/beep_decode.sv
// beep_decode: measures buzzer half-periods between synchronized edges
// and locks onto one of three nominal tones after CONFIRM matches.
module beep_decode #(
  parameter int HALF_W  = 20,
  parameter int T0_HALF = 95420,
  parameter int T1_HALF = 75758,
  parameter int T2_HALF = 63776,
  parameter int TOL     = 2000,
  parameter int CONFIRM = 4,
  parameter int SILENCE = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beep,
  output logic [1:0]        tone_code,
  output logic              tone_valid,
  output logic              tone_active,
  output logic              tone_end,
  output logic [HALF_W-1:0] half_period
);

  // The counter must reach SILENCE even when HALF_W is narrower,
  // so it is sized for both; measurements clamp to HALF_W all-ones.
  localparam int SW = $clog2(SILENCE + 1);
  localparam int CW = (SW > HALF_W) ? SW : HALF_W;
  localparam int MW = $clog2(CONFIRM + 1);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] SIL     = CW'(SILENCE);
  localparam logic [CW-1:0] H_MAX   = CW'({HALF_W{1'b1}});
  localparam logic [MW-1:0] CONF    = MW'(CONFIRM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COUNT  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              sync3_q;
  logic              edge_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [1:0]        cand_q;
  logic [MW-1:0]     match_q;
  logic [1:0]        code_q;
  logic              valid_q;
  logic              active_q;
  logic              end_q;
  logic [HALF_W-1:0] half_q;

  logic [HALF_W-1:0] meas;
  logic [1:0]        cls;
  logic              silence;

  function automatic logic in_win(
    input logic [HALF_W-1:0] h,
    input longint            t
  );
    longint hv;
    hv = longint'(h);
    return (hv >= t - longint'(TOL)) && (hv <= t + longint'(TOL));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= beep;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q ^ sync3_q;
    end
  end

  assign silence = (cnt_q >= SIL);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_q) begin
      cnt_d = CW'(1);
    end else if (state_q == IDLE || silence) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign meas = (cnt_q > H_MAX) ? H_MAX[HALF_W-1:0]
                                : cnt_q[HALF_W-1:0];

  always_comb begin
    cls = 2'd3;
    if (in_win(meas, longint'(T0_HALF))) begin
      cls = 2'd0;
    end else if (in_win(meas, longint'(T1_HALF))) begin
      cls = 2'd1;
    end else if (in_win(meas, longint'(T2_HALF))) begin
      cls = 2'd2;
    end
  end

  // An edge takes priority over the silence timeout in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= 2'd0;
      match_q  <= '0;
      code_q   <= 2'd0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      end_q    <= 1'b0;
      half_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      if (edge_q) begin
        if (state_q != IDLE) begin
          half_q <= meas;
        end
        unique case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (cls != 2'd3) begin
              cand_q  <= cls;
              match_q <= MW'(1);
              state_q <= COUNT;
            end
          end
          COUNT: begin
            if (cls == 2'd3) begin
              state_q <= ARMED;
            end else if (cls == cand_q) begin
              match_q <= match_q + MW'(1);
              if (match_q + MW'(1) == CONF) begin
                state_q  <= LOCKED;
                valid_q  <= 1'b1;
                active_q <= 1'b1;
                code_q   <= cand_q;
              end
            end else begin
              cand_q  <= cls;
              match_q <= MW'(1);
            end
          end
          LOCKED: begin
            if (cls != cand_q) begin
              end_q    <= 1'b1;
              active_q <= 1'b0;
              if (cls == 2'd3) begin
                state_q <= ARMED;
              end else begin
                cand_q  <= cls;
                match_q <= MW'(1);
                state_q <= COUNT;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end else if (state_q != IDLE && silence) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
        if (state_q == LOCKED) begin
          end_q <= 1'b1;
        end
      end
    end
  end

  assign tone_code   = code_q;
  assign tone_valid  = valid_q;
  assign tone_active = active_q;
  assign tone_end    = end_q;
  assign half_period = half_q;

endmodule
